// File: rtl/interrupt_sequencer_if.sv
// Interrupt sequencer datapath bundle: cause/status/pc inputs from the pipeline
// and the SPR write port / PC redirect outputs back to it.
interface interrupt_sequencer_if #(
    parameter int NCAUSE = 23
);
    logic [NCAUSE-1:0] ca;
    logic [31:0]       sr;
    logic [31:0]       esr;
    logic [31:0]       epc;
    logic              eret;
    logic [31:0]       pc;
    logic [31:0]       next_pc;
    logic [31:0]       ea;
    logic              mode;

    logic              stall;
    logic              spr_we;
    logic [2:0]        spr_addr;
    logic [31:0]       spr_wdata;
    logic              pc_load;
    logic [31:0]       pc_target;
    logic              mode_out;
    logic              jisr;
    logic [4:0]        il;
    logic              busy;

    // slave: the sequencer itself; master: the pipeline / datapath side
    modport slave (
        input  ca, sr, esr, epc, eret, pc, next_pc, ea, mode,
        output stall, spr_we, spr_addr, spr_wdata, pc_load, pc_target,
               mode_out, jisr, il, busy
    );
    modport master (
        output ca, sr, esr, epc, eret, pc, next_pc, ea, mode,
        input  stall, spr_we, spr_addr, spr_wdata, pc_load, pc_target,
               mode_out, jisr, il, busy
    );
endinterface

// File: rtl/interrupt_sequencer.sv
// Interrupt/exception sequencer: saves ESR/ECA/EPC/EDATA/SR one per cycle through
// the single SPR port, vectors to the ISR, and handles eret restore.
//
// state   | meaning
// IDLE    | waiting for a pending cause or an eret
// S_ESR   | writing saved status into ESR
// S_ECA   | writing masked cause vector into ECA
// S_EPC   | writing return pc into EPC
// S_EDATA | writing effective address into EDATA
// VECTOR  | clearing SR, redirecting pc to the ISR, jisr pulse
// R_SR    | eret: restoring SR from ESR
// R_JUMP  | eret: jumping back to EPC, restoring mode
module interrupt_sequencer #(
    parameter int              NCAUSE       = 23,
    parameter int              NUM_INTERNAL = 7,
    parameter logic [31:0]     SISR_ADDR    = 32'h0000_0000,
    parameter logic [NCAUSE-1:0] RPT_MASK   = 'h18
) (
    input  logic                  clk,
    input  logic                  reset,
    interrupt_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE, S_ESR, S_ECA, S_EPC, S_EDATA, VECTOR, R_SR, R_JUMP
    } state_t;

    state_t            state;
    logic [NCAUSE-1:0] mca;
    logic              pending;
    logic [4:0]        il_next;

    logic [31:0]       sr_q;
    logic [31:0]       mca_q;
    logic [31:0]       epc_q;
    logic [31:0]       ea_q;
    logic              mode_q;
    logic              saved_mode;

    always_comb begin
        mca = '0;
        for (int i = 0; i < NCAUSE; i++) begin
            mca[i] = (i < NUM_INTERNAL) ? bus.ca[i] : (bus.ca[i] & bus.sr[i]);
        end
    end

    assign pending = |mca;

    always_comb begin
        il_next = '0;
        for (int i = NCAUSE - 1; i >= 0; i--) begin
            if (mca[i]) il_next = 5'(i);
        end
    end

    // Outputs are registered for the state being entered, so they track state exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            bus.stall      <= 1'b0;
            bus.spr_we     <= 1'b0;
            bus.spr_addr   <= '0;
            bus.spr_wdata  <= '0;
            bus.pc_load    <= 1'b0;
            bus.pc_target  <= '0;
            bus.mode_out   <= 1'b0;
            bus.jisr       <= 1'b0;
            bus.il         <= '0;
            bus.busy       <= 1'b0;
            sr_q           <= '0;
            mca_q          <= '0;
            epc_q          <= '0;
            ea_q           <= '0;
            mode_q         <= 1'b0;
            saved_mode     <= 1'b0;
        end else begin
            bus.stall     <= 1'b0;
            bus.spr_we    <= 1'b0;
            bus.spr_addr  <= '0;
            bus.spr_wdata <= '0;
            bus.pc_load   <= 1'b0;
            bus.jisr      <= 1'b0;
            bus.busy      <= 1'b0;
            case (state)
                IDLE: begin
                    if (pending) begin
                        sr_q          <= bus.sr;
                        mca_q         <= 32'(mca);
                        epc_q         <= RPT_MASK[il_next] ? bus.pc : bus.next_pc;
                        ea_q          <= bus.ea;
                        mode_q        <= bus.mode;
                        bus.il        <= il_next;
                        state         <= S_ESR;
                        bus.stall     <= 1'b1;
                        bus.busy      <= 1'b1;
                        bus.spr_we    <= 1'b1;
                        bus.spr_addr  <= 3'd1;
                        bus.spr_wdata <= bus.sr;
                    end else if (bus.eret && !bus.mode_out) begin
                        epc_q         <= bus.epc;
                        state         <= R_SR;
                        bus.stall     <= 1'b1;
                        bus.busy      <= 1'b1;
                        bus.spr_we    <= 1'b1;
                        bus.spr_addr  <= 3'd0;
                        bus.spr_wdata <= bus.esr;
                    end
                end
                S_ESR: begin
                    state         <= S_ECA;
                    bus.stall     <= 1'b1;
                    bus.busy      <= 1'b1;
                    bus.spr_we    <= 1'b1;
                    bus.spr_addr  <= 3'd2;
                    bus.spr_wdata <= mca_q;
                end
                S_ECA: begin
                    state         <= S_EPC;
                    bus.stall     <= 1'b1;
                    bus.busy      <= 1'b1;
                    bus.spr_we    <= 1'b1;
                    bus.spr_addr  <= 3'd3;
                    bus.spr_wdata <= epc_q;
                end
                S_EPC: begin
                    state         <= S_EDATA;
                    bus.stall     <= 1'b1;
                    bus.busy      <= 1'b1;
                    bus.spr_we    <= 1'b1;
                    bus.spr_addr  <= 3'd4;
                    bus.spr_wdata <= ea_q;
                end
                S_EDATA: begin
                    state         <= VECTOR;
                    bus.stall     <= 1'b1;
                    bus.busy      <= 1'b1;
                    bus.spr_we    <= 1'b1;
                    bus.spr_addr  <= 3'd0;
                    bus.spr_wdata <= '0;
                    bus.pc_load   <= 1'b1;
                    bus.pc_target <= SISR_ADDR;
                    bus.jisr      <= 1'b1;
                end
                VECTOR: begin
                    state        <= IDLE;
                    bus.mode_out <= 1'b0;
                    saved_mode   <= mode_q;
                end
                R_SR: begin
                    state         <= R_JUMP;
                    bus.stall     <= 1'b1;
                    bus.busy      <= 1'b1;
                    bus.pc_load   <= 1'b1;
                    bus.pc_target <= epc_q;
                end
                R_JUMP: begin
                    state        <= IDLE;
                    bus.mode_out <= saved_mode;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: directed test-plan steps followed by
// random cause/status/eret traffic checked against a transaction-level model.
module tb_interrupt_sequencer;

    localparam int          NCAUSE       = 23;
    localparam logic [22:0] RPT          = 23'h000018;
    localparam logic [22:0] INTERNAL_SET = 23'h00007F;
    localparam logic [31:0] SISR         = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    interrupt_sequencer_if #(.NCAUSE(NCAUSE)) bus();

    interrupt_sequencer #(.NCAUSE(NCAUSE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic       m_mode_out;
    logic       m_saved_mode;
    logic [4:0] m_il;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [22:0] c, input logic [31:0] s, input logic [31:0] esr_v,
                         input logic [31:0] epc_v, input logic er, input logic [31:0] p,
                         input logic [31:0] np, input logic [31:0] e, input logic m);
        bus.ca = c;  bus.sr = s;  bus.esr = esr_v;  bus.epc = epc_v;  bus.eret = er;
        bus.pc = p;  bus.next_pc = np;  bus.ea = e;  bus.mode = m;
    endtask

    task automatic clear_inputs();
        drive('0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic scramble();
        drive(23'($urandom), $urandom, $urandom, $urandom, 1'b1, $urandom, $urandom,
              $urandom, 1'($urandom));
    endtask

    // Starts and ends at a negedge; applies one IDLE-cycle input set and checks the outcome.
    task automatic run(input logic [22:0] c, input logic [31:0] s, input logic [31:0] esr_v,
                       input logic [31:0] epc_v, input logic er, input logic [31:0] p,
                       input logic [31:0] np, input logic [31:0] e, input logic m);
        logic [22:0] mca;
        int          low;
        logic [2:0]  waddr [5];
        logic [31:0] wdata [5];
        mca = c & (s[22:0] | INTERNAL_SET);
        low = -1;
        for (int i = 0; i < NCAUSE; i++) if (mca[i] && low < 0) low = i;
        drive(c, s, esr_v, epc_v, er, p, np, e, m);
        @(posedge clk);
        @(negedge clk);
        if (mca != 0) begin
            waddr = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
            wdata = '{s, 32'(mca), RPT[low] ? p : np, e, 32'd0};
            scramble();
            for (int k = 0; k < 5; k++) begin
                check("irq_stall",  32'(bus.stall),   32'd1);
                check("irq_we",     32'(bus.spr_we),  32'd1);
                check("irq_addr",   32'(bus.spr_addr), 32'(waddr[k]));
                check("irq_wdata",  bus.spr_wdata,    wdata[k]);
                check("irq_pcload", 32'(bus.pc_load), (k == 4) ? 32'd1 : 32'd0);
                check("irq_jisr",   32'(bus.jisr),    (k == 4) ? 32'd1 : 32'd0);
                check("irq_busy",   32'(bus.busy),    32'd1);
                check("irq_il",     32'(bus.il),      32'(low));
                if (k == 4) begin
                    check("irq_target", bus.pc_target, SISR);
                    clear_inputs();
                end
                @(negedge clk);
            end
            m_saved_mode = m;
            m_mode_out   = 1'b0;
            m_il         = 5'(low);
            check("irq_done_stall", 32'(bus.stall),    32'd0);
            check("irq_done_busy",  32'(bus.busy),     32'd0);
            check("irq_done_mode",  32'(bus.mode_out), 32'd0);
        end else if (er && !m_mode_out) begin
            scramble();
            check("eret_sr_we",    32'(bus.spr_we),   32'd1);
            check("eret_sr_addr",  32'(bus.spr_addr), 32'd0);
            check("eret_sr_data",  bus.spr_wdata,     esr_v);
            check("eret_sr_stall", 32'(bus.stall),    32'd1);
            check("eret_sr_pcld",  32'(bus.pc_load),  32'd0);
            @(negedge clk);
            clear_inputs();
            check("eret_j_pcld",   32'(bus.pc_load),  32'd1);
            check("eret_j_target", bus.pc_target,     epc_v);
            check("eret_j_we",     32'(bus.spr_we),   32'd0);
            check("eret_j_stall",  32'(bus.stall),    32'd1);
            @(negedge clk);
            m_mode_out = m_saved_mode;
            check("eret_done_mode",  32'(bus.mode_out), 32'(m_mode_out));
            check("eret_done_stall", 32'(bus.stall),    32'd0);
        end else begin
            check("idle_stall", 32'(bus.stall),    32'd0);
            check("idle_we",    32'(bus.spr_we),   32'd0);
            check("idle_pcld",  32'(bus.pc_load),  32'd0);
            check("idle_busy",  32'(bus.busy),     32'd0);
            check("idle_il",    32'(bus.il),       32'(m_il));
            check("idle_mode",  32'(bus.mode_out), 32'(m_mode_out));
            clear_inputs();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"},  32'(bus.stall),    32'd0);
        check({tag, "_we"},     32'(bus.spr_we),   32'd0);
        check({tag, "_addr"},   32'(bus.spr_addr), 32'd0);
        check({tag, "_wdata"},  bus.spr_wdata,     32'd0);
        check({tag, "_pcld"},   32'(bus.pc_load),  32'd0);
        check({tag, "_target"}, bus.pc_target,     32'd0);
        check({tag, "_mode"},   32'(bus.mode_out), 32'd0);
        check({tag, "_jisr"},   32'(bus.jisr),     32'd0);
        check({tag, "_il"},     32'(bus.il),       32'd0);
        check({tag, "_busy"},   32'(bus.busy),     32'd0);
    endtask

    initial begin
        logic [22:0] rc;
        reset = 1'b1;
        clear_inputs();
        m_mode_out = 1'b0;  m_saved_mode = 1'b0;  m_il = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // sysc from user mode, then eret back, then a second eret in user mode
        run(23'h000020, 32'h0, 32'h0, 32'h0, 1'b0, 32'h100, 32'h104, 32'h2000, 1'b1);
        run(23'h0, 32'h0, 32'h400, 32'h104, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
        run(23'h0, 32'h0, 32'h777, 32'h888, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
        // page fault repeats the faulting pc
        run(23'h000008, 32'h0, 32'h0, 32'h0, 1'b0, 32'h40, 32'h44, 32'h3000, 1'b0);
        // maskable cause 10, masked then unmasked
        run(23'h000400, 32'h0, 32'h0, 32'h0, 1'b0, 32'h80, 32'h84, 32'h0, 1'b1);
        run(23'h000400, 32'h400, 32'h0, 32'h0, 1'b0, 32'h80, 32'h84, 32'h10, 1'b1);
        // two causes: lowest index wins, ECA holds both
        run(23'h001004, 32'h1000, 32'h0, 32'h0, 1'b0, 32'h200, 32'h204, 32'h20, 1'b0);

        // reset in the middle of the save sequence
        drive(23'h000040, 32'h0, 32'h0, 32'h0, 1'b0, 32'h300, 32'h304, 32'h30, 1'b1);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_addr", 32'(bus.spr_addr), 32'd3);
        reset = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(negedge clk);
        check_all_zero("midreset");
        reset = 1'b0;
        m_mode_out = 1'b0;  m_saved_mode = 1'b0;  m_il = '0;
        @(negedge clk);
        check("post_reset_we",    32'(bus.spr_we), 32'd0);
        check("post_reset_stall", 32'(bus.stall),  32'd0);

        // pending cause and eret together: interrupt wins
        run(23'h000002, 32'h0, 32'h55, 32'h66, 1'b1, 32'h500, 32'h504, 32'h50, 1'b1);
        run(23'h0, 32'h0, 32'h55, 32'h66, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0:       rc = '0;
                1:       rc = 23'($urandom) & 23'($urandom) & 23'($urandom);
                2:       rc = 23'($urandom) & ~INTERNAL_SET;
                default: rc = 23'(1) << $urandom_range(0, NCAUSE - 1);
            endcase
            run(rc, $urandom, $urandom, $urandom, 1'($urandom), $urandom, $urandom,
                $urandom, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
